uart_tx: RTL
============

Name: uart_tx

Overview:
- Serial transmitter: the neighbouring stage on the opposite end of the line from the UART receiver FSM.
- Accepts one parallel byte on a start strobe and drives an 8N1-style frame (configurable stop bits) onto Bit_out.
- Bit_out connects directly, or through the pad, to the receiver's Bit_in.
- Bit timing comes from an internal per-bit cycle counter, so no external baud enable is needed.

Parameters:
CLKS_PER_BIT, 16, clk cycles each serial bit is held; legal range 2..65535.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset; 0 forces reset immediately, independent of clk.
start  input  1  transmit request, sampled only while in IDLE.
data  input  8  byte to send; captured on the accepting edge.
Bit_out  output  1  serial line, idles high.
bussy  output  1  high while a frame is in progress (START_BIT..STOP_BIT).
done  output  1  single-cycle pulse when a frame completes.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, Bit_out=1, bussy=0, done=0, shift register=0, bit counter=0, cycle counter=0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, START_BIT, SEND_DATA, STOP_BIT.
- IDLE:
  - Bit_out=1, bussy=0.
  - On an edge with start=1: latch data into the shift register, clear both counters, go to START_BIT.
  - From that edge: Bit_out=0, bussy=1.
- START_BIT:
  - Bit_out=0 for exactly CLKS_PER_BIT cycles.
  - Then go to SEND_DATA with Bit_out=data[0].
- SEND_DATA:
  - Bits sent LSB first; each bit is held CLKS_PER_BIT cycles.
  - Shift right after each bit; 3-bit bit counter counts 0..7.
  - After bit 7's final cycle, go to STOP_BIT with Bit_out=1.
- STOP_BIT:
  - Bit_out=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - Then go to IDLE: bussy=0 and done=1 for exactly that first IDLE cycle.
- Frame length: bussy is high for exactly (9+STOP_BITS)*CLKS_PER_BIT cycles.
- Counter width: cycle counter is $clog2(CLKS_PER_BIT*STOP_BITS) bits. It wraps to 0 at each bit boundary and never overflows.
- start while bussy=1: ignored, with no effect on the frame in progress.
- data changing mid-frame: no effect; only the latched copy is sent.
- start held high continuously: back-to-back frames, each separated by exactly one IDLE cycle. That cycle is the done cycle, with Bit_out=1.
- start=1 in the done cycle: accepted at the next edge, same as any IDLE cycle.
- Reset mid-frame: Bit_out returns high asynchronously and the frame is abandoned. No done pulse is issued. After reset releases, the next start begins a fresh frame.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants IDLE=0, START_BIT=1, SEND_DATA=2, STOP_BIT=3 (3-bit, as in the receiver);
  - DATA_BITS=8;
  - default CLKS_PER_BIT.
- One natural sub-module, uart_bit_timer: the per-bit cycle counter.
  - Inputs: clk, reset, clear, load_len.
  - Output: bit_end pulse.
  - The receiver can reuse it for mid-bit sampling.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release, no start for 50 cycles -> Bit_out=1, bussy=0, done=0 throughout.
- Single frame, CLKS_PER_BIT=4, STOP_BITS=1, data=0x55, 1-cycle start pulse:
  - Bit_out sequence in 4-cycle groups is 0,1,0,1,0,1,0,1,0,1;
  - bussy high for 40 cycles;
  - done high on cycle 41 only.
- Ignored start: send 0xA3; pulse start with data=0xFF at cycle 10 of the frame -> line carries 0xA3 LSB-first (1,1,0,0,0,1,0,1); exactly one done.
- Back-to-back: start held high, data=0x00 then 0xFF -> two frames, a single Bit_out=1 done cycle between them, two done pulses 41 cycles apart (CLKS_PER_BIT=4).
- Two stop bits, STOP_BITS=2, CLKS_PER_BIT=4, data=0x81 -> stop high for 8 cycles; bussy high for 44 cycles.
- Reset mid-frame: assert reset=0 asynchronously (between edges) during bit 3 -> Bit_out=1 and bussy=0 immediately, no done. Then a new start with 0x3C -> clean full frame of 0x3C.
- Loopback with the receiver: connect Bit_out to Rx Bit_in at matching bit timing, send 0x00, 0x5A, 0xFF -> receiver out matches each byte.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and shared constants for the UART transmitter and receiver
package uart_pkg;
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START_BIT = 3'd1,
      SEND_DATA = 3'd2,
      STOP_BIT  = 3'd3
   } state_t;
   localparam int DATA_BITS            = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 16;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: per-bit cycle counter; bit_end marks the last cycle of the current bit
module uart_bit_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic [W-1:0] load_len,
   output logic         bit_end
);
   logic [W-1:0] r_cnt;
   // load_len is the terminal count (bit length minus one), so the counter never exceeds it
   assign bit_end = !clear && (r_cnt == load_len);
   // Count up within a bit, wrap to zero at each bit boundary, hold at zero while cleared
   always_ff @(posedge clk or negedge reset)
      if (!reset) r_cnt <= '0;
      else if (clear || bit_end) r_cnt <= '0;
      else r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: serial transmitter sending start bit, 8 data bits LSB first and configurable stop bits
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] data,
   output logic                 Bit_out,
   output logic                 bussy,
   output logic                 done
);
   localparam int CW = $clog2(CLKS_PER_BIT * STOP_BITS);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT * STOP_BITS - 1);
   state_t               r_state, w_state_n;
   logic [DATA_BITS-1:0] r_shift, w_shift_n;
   logic [2:0]           r_bit_cnt, w_bit_cnt_n;
   logic                 r_bit_out, w_bit_out_n;
   logic                 r_bussy, w_bussy_n;
   logic                 r_done, w_done_n;
   logic                 w_clear, w_bit_end;
   logic [CW-1:0]        w_len;
   // The timer idles at zero so every frame starts its first bit on a fresh count
   assign w_clear = (r_state == IDLE);
   assign w_len   = (r_state == STOP_BIT) ? STOP_LAST : BIT_LAST;
   uart_bit_timer #(.W(CW)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (w_clear),
      .load_len(w_len),
      .bit_end (w_bit_end)
   );
   // State, data and registered outputs; line idles high out of reset
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_bit_out <= 1'b1;
         r_bussy   <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_shift   <= w_shift_n;
         r_bit_cnt <= w_bit_cnt_n;
         r_bit_out <= w_bit_out_n;
         r_bussy   <= w_bussy_n;
         r_done    <= w_done_n;
      end
   // Next state and next output values; the line value is computed one cycle ahead so outputs stay registered
   always_comb begin
      w_state_n   = r_state;
      w_shift_n   = r_shift;
      w_bit_cnt_n = r_bit_cnt;
      w_bit_out_n = r_bit_out;
      w_bussy_n   = r_bussy;
      w_done_n    = 1'b0;
      case (r_state)
         IDLE: if (start) begin
            w_state_n   = START_BIT;
            w_shift_n   = data;
            w_bit_cnt_n = '0;
            w_bit_out_n = 1'b0;
            w_bussy_n   = 1'b1;
         end
         START_BIT: if (w_bit_end) begin
            w_state_n   = SEND_DATA;
            w_bit_out_n = r_shift[0];
         end
         SEND_DATA: if (w_bit_end) begin
            if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
               w_state_n   = STOP_BIT;
               w_bit_out_n = 1'b1;
            end else begin
               w_shift_n   = r_shift >> 1;
               w_bit_out_n = r_shift[1];
               w_bit_cnt_n = r_bit_cnt + 1'b1;
            end
         end
         STOP_BIT: if (w_bit_end) begin
            w_state_n = IDLE;
            w_bussy_n = 1'b0;
            w_done_n  = 1'b1;
         end
         default: begin
            w_state_n   = IDLE;
            w_bit_out_n = 1'b1;
            w_bussy_n   = 1'b0;
         end
      endcase
   end
   assign Bit_out = r_bit_out;
   assign bussy   = r_bussy;
   assign done    = r_done;
endmodule
